// File: rtl/logic_processor_param.sv
// logic_processor_param: two WIDTH-bit registers A/B combined by a bitwise
// function F and routed back per R, processed BITS_PER_CYCLE bits per clock.
// Optional macro LOGIC_PROC_OPCOUNT_EN enables the 8-bit completed-op counter;
// without it OpCount is tied to zero.
module logic_processor_param #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       F,
  input  logic [1:0]       R,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done,
  output logic [7:0]       OpCount
);

  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = WIDTH / K;
  localparam int CW = $clog2(N) + 1;

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("logic_processor_param: WIDTH must be 2..64");
  end
  if (K < 1 || (WIDTH % K) != 0) begin : g_bad_k
    $error("logic_processor_param: BITS_PER_CYCLE must divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]      f_q, f_d;
  logic [1:0]      r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  logic [K-1:0]     a_lo, b_lo, y_lo, a_new, b_new;
  logic [WIDTH-1:0] a_rot, b_rot;

  assign a_lo = a_q[K-1:0];
  assign b_lo = b_q[K-1:0];

  // Bitwise function on the low chunk, using the captured select
  always_comb begin
    y_lo = '0;
    case (f_q)
      3'b000: y_lo = a_lo & b_lo;
      3'b001: y_lo = a_lo | b_lo;
      3'b010: y_lo = a_lo ^ b_lo;
      3'b011: y_lo = '1;
      3'b100: y_lo = ~(a_lo & b_lo);
      3'b101: y_lo = ~(a_lo | b_lo);
      3'b110: y_lo = ~(a_lo ^ b_lo);
      3'b111: y_lo = '0;
      default: y_lo = '0;
    endcase
  end

  // Routing of the low chunk back into A/B
  always_comb begin
    a_new = a_lo;
    b_new = b_lo;
    case (r_q)
      2'b01: b_new = y_lo;
      2'b10: a_new = y_lo;
      2'b11: begin a_new = b_lo; b_new = a_lo; end
      default: ;
    endcase
  end

  // Rotate right by K with the routed chunk entering at the top; after N
  // steps every bit is back in its home position.
  if (K == WIDTH) begin : g_rot_full
    assign a_rot = a_new;
    assign b_rot = b_new;
  end else begin : g_rot_part
    assign a_rot = {a_new, a_q[WIDTH-1:K]};
    assign b_rot = {b_new, b_q[WIDTH-1:K]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Execute) begin
          // Execute has priority over loads
          f_d     = F;
          r_d     = R;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          if (LoadA) a_d = Din;
          if (LoadB) b_d = Din;
        end
      end
      SHIFT: begin
        a_d = a_rot;
        b_d = b_rot;
        if (cnt_q == CW'(N - 1)) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (!Execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef LOGIC_PROC_OPCOUNT_EN
  logic [7:0] opcnt_q;
  // Completed-operation counter, bumps on SHIFT exit, wraps naturally
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)      opcnt_q <= '0;
    else if (done_d) opcnt_q <= opcnt_q + 8'd1;
  end
  assign OpCount = opcnt_q;
`else
  assign OpCount = '0;
`endif

  assign Aval = a_q;
  assign Bval = b_q;
  assign Busy = (state_q == SHIFT);
  assign Done = done_q;

endmodule

// File: tb/tb_logic_processor_param.sv
// Directed bench for logic_processor_param: one 8-bit/1-bit-per-cycle
// instance and one 16-bit/4-bits-per-cycle instance on a shared clock.
module tb_logic_processor_param;

`ifdef LOGIC_PROC_OPCOUNT_EN
  localparam bit OPC_EN = 1'b1;
`else
  localparam bit OPC_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       LoadA, LoadB, Execute;
  logic [7:0] Din;
  logic [2:0] F;
  logic [1:0] R;
  logic [7:0] Aval, Bval, OpCount;
  logic       Busy, Done;

  logic        wLoadA, wLoadB, wExecute;
  logic [15:0] wDin, wAval, wBval;
  logic [2:0]  wF;
  logic [1:0]  wR;
  logic        wBusy, wDone;
  logic [7:0]  wOpCount;

  always #5 Clk = ~Clk;

  logic_processor_param #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
    .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
    .Din(Din), .F(F), .R(R), .Aval(Aval), .Bval(Bval), .Busy(Busy),
    .Done(Done), .OpCount(OpCount));

  logic_processor_param #(.WIDTH(16), .BITS_PER_CYCLE(4)) u16 (
    .Clk(Clk), .Reset(Reset), .LoadA(wLoadA), .LoadB(wLoadB), .Execute(wExecute),
    .Din(wDin), .F(wF), .R(wR), .Aval(wAval), .Bval(wBval), .Busy(wBusy),
    .Done(wDone), .OpCount(wOpCount));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  // Called one edge into SHIFT; returns number of Busy cycles seen
  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (Busy && cyc < 40) begin cyc++; step(); end
  endtask

  // Launch an 8-bit op with a one-cycle Execute pulse, check length and Done
  task automatic op8(input string tag, input logic [2:0] f, input logic [1:0] r);
    int cyc;
    F = f; R = r; Execute = 1'b1;
    step();
    Execute = 1'b0;
    wait_busy(cyc);
    chk({tag, "_busy"}, cyc, 8);
    chk({tag, "_done"}, Done, 1);
    step();
    chk({tag, "_done_off"}, Done, 0);
  endtask

  initial begin
    int cyc, dones;
    Reset = 1'b0; LoadA = 0; LoadB = 0; Execute = 0; Din = '0; F = '0; R = '0;
    wLoadA = 0; wLoadB = 0; wExecute = 0; wDin = '0; wF = '0; wR = '0;
    #12;
    chk("rst_A", Aval, 0); chk("rst_B", Bval, 0); chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0); chk("rst_opc", OpCount, 0);
    step(); Reset = 1'b1; step();

    // 16-bit, 4 bits/cycle: NAND routed to A
    wLoadA = 1; wDin = 16'hF0F0; step(); wLoadA = 0;
    wLoadB = 1; wDin = 16'hFF00; step(); wLoadB = 0;
    wF = 3'b100; wR = 2'b10; wExecute = 1; step(); wExecute = 0;
    cyc = 0;
    while (wBusy && cyc < 40) begin cyc++; step(); end
    chk("w16_busy", cyc, 4);
    chk("w16_done", wDone, 1);
    chk("w16_A", wAval, 16'h0FFF); chk("w16_B", wBval, 16'hFF00);
    chk("w16_opc", wOpCount, OPC_EN ? 1 : 0);

    // Loads in IDLE
    LoadA = 1; Din = 8'h33; step(); LoadA = 0;
    LoadB = 1; Din = 8'h55; step(); LoadB = 0;
    chk("ld_A", Aval, 8'h33); chk("ld_B", Bval, 8'h55);

    op8("xor_toA", 3'b010, 2'b10);
    chk("xor_A", Aval, 8'h66); chk("xor_B", Bval, 8'h55);
    op8("xnor_toB", 3'b110, 2'b01);
    chk("xnor_A", Aval, 8'h66); chk("xnor_B", Bval, 8'hCC);
    op8("swap", 3'b110, 2'b11);
    chk("swap_A", Aval, 8'hCC); chk("swap_B", Bval, 8'h66);
    chk("opc3", OpCount, OPC_EN ? 3 : 0);

    // Execute held 20 cycles, LoadA pulsed during HOLD
    F = 3'b000; R = 2'b00; Execute = 1; dones = 0;
    for (int i = 0; i < 20; i++) begin
      LoadA = (i == 12); Din = 8'hAA;
      step();
      if (Done) dones++;
    end
    LoadA = 0; Execute = 0; step();
    chk("hold_dones", dones, 1);
    chk("hold_A", Aval, 8'hCC);
    chk("opc4", OpCount, OPC_EN ? 4 : 0);

    // Back in IDLE: load works; then Load+Execute together -> no load
    LoadA = 1; Din = 8'h12; step(); LoadA = 0;
    chk("idle_ld_A", Aval, 8'h12);
    LoadA = 1; LoadB = 1; Din = 8'hFF;
    op8("exe_wins", 3'b011, 2'b00);
    LoadA = 0; LoadB = 0;
    chk("exe_wins_A", Aval, 8'h12); chk("exe_wins_B", Bval, 8'h66);

    // Reset at SHIFT cycle 3 aborts
    F = 3'b000; R = 2'b10; Execute = 1; step(); Execute = 0;
    step(); step();
    chk("mid_busy", Busy, 1);
    Reset = 0; #1;
    chk("abort_A", Aval, 0); chk("abort_B", Bval, 0);
    chk("abort_busy", Busy, 0); chk("abort_opc", OpCount, 0);
    step(); Reset = 1; dones = 0;
    for (int i = 0; i < 12; i++) begin step(); if (Done) dones++; end
    chk("abort_nodone", dones, 0);

    // F/R changes mid-SHIFT are ignored
    LoadA = 1; Din = 8'h3C; step(); LoadA = 0;
    LoadB = 1; Din = 8'h0F; step(); LoadB = 0;
    F = 3'b001; R = 2'b10; Execute = 1; step(); Execute = 0;
    F = 3'b111; R = 2'b11; step();
    wait_busy(cyc);
    chk("cap_busy", cyc + 1, 8);
    chk("cap_A", Aval, 8'h3F); chk("cap_B", Bval, 8'h0F);
    chk("cap_opc", OpCount, OPC_EN ? 1 : 0);
    step();

    // Execute already high at reset release starts on first edge
    Reset = 0; Execute = 1; F = 3'b011; R = 2'b01; step();
    Reset = 1; step();
    chk("rel_busy", Busy, 1);
    Execute = 0;
    wait_busy(cyc);
    chk("rel_cyc", cyc, 8);
    chk("rel_B", Bval, 8'hFF); chk("rel_A", Aval, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
